// File: rtl/jc_pkg.sv
// Shared definitions for Johnson-code consumers: lock FSM encoding and sequence geometry
// (sequence length and phase-index width derived from the number of stages).
package jc_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_ERROR    = 2'd3
  } jc_state_e;

  function automatic int jc_seq_len(input int width);
    return 2 * width;
  endfunction

  function automatic int jc_idx_w(input int width);
    return (2 * width <= 2) ? 1 : $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code to phase index decoder; valid=0 for any code outside the 2*WIDTH sequence.
// Zero latency, no flow control.
module johnson_code_decode
  import jc_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int N     = jc_seq_len(WIDTH),
  localparam int IW    = jc_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] jc_in,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [WIDTH-1:0] w_ones;

  assign w_ones = '1;

  // Filling phase: k ones entered from the MSB. Draining phase: k ones left at the LSB.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (jc_in == ~(w_ones >> k)) begin
        idx   = IW'(k);
        valid = 1'b1;
      end
    end
    for (int k = 1; k < WIDTH; k++) begin
      if (jc_in == (w_ones >> (WIDTH - k))) begin
        idx   = IW'(N - k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder with step checking, lock FSM and sticky error; 1-cycle registered latency,
// en gates sampling (no backpressure). Revolution counter present only with JC_DEC_REV_CNT_EN.
module johnson_phase_decoder
  import jc_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 3,
  parameter  int REV_W    = 8,
  localparam int N        = jc_seq_len(WIDTH),
  localparam int IW       = jc_idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] jc_in,
  output logic [IW-1:0]    phase_idx,
  output logic [N-1:0]     phase_oh,
  output logic             locked,
  output logic             err,
  output logic [REV_W-1:0] rev_cnt,
  output logic             rev_pulse
);

  localparam int             LCW      = $clog2(LOCK_CNT + 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
  localparam logic [N-1:0]   OH_ONE   = N'(1);

  jc_state_e        r_state;
  jc_state_e        w_state_nxt;
  logic [LCW-1:0]   r_lock_cnt;
  logic [LCW-1:0]   w_lock_cnt_nxt;
  logic             r_prev_valid;
  logic [IW-1:0]    r_idx;
  logic [N-1:0]     r_oh;

  logic [IW-1:0]    w_dec_idx;
  logic             w_dec_valid;
  logic [IW-1:0]    w_idx_inc;
  logic             w_clear;
  logic             w_hold;
  logic             w_good;
  logic             w_bad;

  johnson_code_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .jc_in (jc_in),
    .idx   (w_dec_idx),
    .valid (w_dec_valid)
  );

  // Clearing only means something in ERROR; it then swallows that cycle's sample.
  assign w_clear   = clr_err && (r_state == ST_ERROR);
  assign w_idx_inc = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
  assign w_hold    = r_prev_valid && w_dec_valid && (w_dec_idx == r_idx);
  assign w_good    = r_prev_valid && w_dec_valid && (w_dec_idx == w_idx_inc);
  assign w_bad     = !w_dec_valid || (r_prev_valid && !w_hold && !w_good);

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_clear) begin
      w_state_nxt    = ST_UNLOCKED;
      w_lock_cnt_nxt = '0;
    end else if (en) begin
      unique case (r_state)
        ST_UNLOCKED: begin
          if (w_dec_valid) begin
            w_state_nxt    = ST_LOCKING;
            w_lock_cnt_nxt = '0;
          end
        end
        ST_LOCKING: begin
          if (w_bad) begin
            w_state_nxt    = ST_UNLOCKED;
            w_lock_cnt_nxt = '0;
          end else if (w_good) begin
            if (r_lock_cnt == LCW'(LOCK_CNT - 1)) begin
              w_state_nxt    = ST_LOCKED;
              w_lock_cnt_nxt = '0;
            end else begin
              w_lock_cnt_nxt = r_lock_cnt + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_bad) begin
            w_state_nxt = ST_ERROR;
          end
        end
        ST_ERROR: begin
          w_state_nxt = ST_ERROR;
        end
        default: begin
          w_state_nxt    = ST_UNLOCKED;
          w_lock_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_UNLOCKED;
      r_lock_cnt   <= '0;
      r_prev_valid <= 1'b0;
      r_idx        <= '0;
      r_oh         <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_clear) begin
        r_prev_valid <= 1'b0;
      end else if (en) begin
        // An illegal code keeps the last good index but drops the predecessor.
        r_prev_valid <= w_dec_valid;
        if (w_dec_valid) begin
          r_idx <= w_dec_idx;
          r_oh  <= OH_ONE << w_dec_idx;
        end else begin
          r_oh  <= '0;
        end
      end
    end
  end

  assign phase_idx = r_idx;
  assign phase_oh  = r_oh;
  assign locked    = (r_state == ST_LOCKED);
  assign err       = (r_state == ST_ERROR);

`ifdef JC_DEC_REV_CNT_EN
  logic [REV_W-1:0] r_rev_cnt;
  logic             r_rev_pulse;
  logic             w_rev_step;

  assign w_rev_step = en && (r_state == ST_LOCKED) && w_good && (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rev_cnt   <= '0;
      r_rev_pulse <= 1'b0;
    end else begin
      r_rev_pulse <= w_rev_step;
      if (w_rev_step) begin
        r_rev_cnt <= r_rev_cnt + 1'b1;
      end
    end
  end

  assign rev_cnt   = r_rev_cnt;
  assign rev_pulse = r_rev_pulse;
`else
  assign rev_cnt   = '0;
  assign rev_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed scoreboard bench for johnson_phase_decoder (WIDTH=4, LOCK_CNT=3, REV_W=8).
module tb_johnson_phase_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr_err;
  logic [3:0] jc_in;
  logic [2:0] phase_idx;
  logic [7:0] phase_oh;
  logic       locked;
  logic       err;
  logic [7:0] rev_cnt;
  logic       rev_pulse;

  johnson_phase_decoder #(
    .WIDTH    (4),
    .LOCK_CNT (3),
    .REV_W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr_err   (clr_err),
    .jc_in     (jc_in),
    .phase_idx (phase_idx),
    .phase_oh  (phase_oh),
    .locked    (locked),
    .err       (err),
    .rev_cnt   (rev_cnt),
    .rev_pulse (rev_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [21:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  event chk_now;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] jc_code(input int i);
    case (i)
      0: return 4'b0000;
      1: return 4'b1000;
      2: return 4'b1100;
      3: return 4'b1110;
      4: return 4'b1111;
      5: return 4'b0111;
      6: return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [7:0] oh(input int i);
    logic [7:0] one;
    one = 8'h01;
    return one << i;
  endfunction

  // Without the revolution feature both counter outputs are tied low.
  function automatic logic [21:0] pack(input int xi, input logic [7:0] xoh, input logic xl,
                                       input logic xe, input int xr, input logic xp);
    logic [7:0] r;
    logic       p;
`ifdef JC_DEC_REV_CNT_EN
    r = 8'(xr);
    p = xp;
`else
    r = 8'h00;
    p = 1'b0;
`endif
    return {3'(xi), xoh, xl, xe, r, p};
  endfunction

  task automatic step(input string nm, input logic e, input logic c, input logic [3:0] code,
                      input int xi, input logic [7:0] xoh, input logic xl, input logic xe,
                      input int xr, input logic xp);
    exp_t t;
    en      = e;
    clr_err = c;
    jc_in   = code;
    t.cyc   = cyc + 1;
    t.name  = nm;
    t.exp   = pack(xi, xoh, xl, xe, xr, xp);
    sb_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk or chk_now) begin
    exp_t        e;
    logic [21:0] obs;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e   = sb_q.pop_front();
      obs = {phase_idx, phase_oh, locked, err, rev_cnt, rev_pulse};
      checks++;
      if (e.cyc >= 0 && e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got idx=%0d oh=%b locked=%b err=%b rev=%0d pulse=%b, want idx=%0d oh=%b locked=%b err=%b rev=%0d pulse=%b",
                 e.name, phase_idx, phase_oh, locked, err, rev_cnt, rev_pulse,
                 e.exp[21:19], e.exp[18:11], e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    exp_t t;
    rst_n   = 1'b0;
    en      = 1'b0;
    clr_err = 1'b0;
    jc_in   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("reset_state", 0, 0, 4'b1010, 0, 8'h00, 0, 0, 0, 0);

    // Acquire lock: first legal code, then three good steps.
    step("lock_1000", 1, 0, 4'b1000, 1, 8'h02, 0, 0, 0, 0);
    step("lock_1100", 1, 0, 4'b1100, 2, 8'h04, 0, 0, 0, 0);
    step("lock_1110", 1, 0, 4'b1110, 3, 8'h08, 0, 0, 0, 0);
    step("lock_1111", 1, 0, 4'b1111, 4, 8'h10, 1, 0, 0, 0);

    step("rev_0111",  1, 0, 4'b0111, 5, 8'h20, 1, 0, 0, 0);
    step("rev_0011",  1, 0, 4'b0011, 6, 8'h40, 1, 0, 0, 0);
    step("rev_0001",  1, 0, 4'b0001, 7, 8'h80, 1, 0, 0, 0);
    step("rev_wrap",  1, 0, 4'b0000, 0, 8'h01, 1, 0, 1, 1);
    step("rev_after", 1, 0, 4'b1000, 1, 8'h02, 1, 0, 1, 0);

    for (int r = 2; r <= 256; r++) begin
      for (int i = 2; i < 8; i++) begin
        step("rev_loop", 1, 0, jc_code(i), i, oh(i), 1, 0, r - 1, 0);
      end
      step("rev_loop_wrap", 1, 0, 4'b0000, 0, 8'h01, 1, 0, r % 256, 1);
      step("rev_loop_next", 1, 0, 4'b1000, 1, 8'h02, 1, 0, r % 256, 0);
    end

    // Freeze with en low while the code wanders, then a HOLD step.
    step("to_1100", 1, 0, 4'b1100, 2, 8'h04, 1, 0, 0, 0);
    step("to_1110", 1, 0, 4'b1110, 3, 8'h08, 1, 0, 0, 0);
    step("frz_0101", 0, 0, 4'b0101, 3, 8'h08, 1, 0, 0, 0);
    step("frz_0000", 0, 0, 4'b0000, 3, 8'h08, 1, 0, 0, 0);
    step("frz_1111", 0, 0, 4'b1111, 3, 8'h08, 1, 0, 0, 0);
    step("frz_0011", 0, 0, 4'b0011, 3, 8'h08, 1, 0, 0, 0);
    step("frz_1001", 0, 0, 4'b1001, 3, 8'h08, 1, 0, 0, 0);
    step("hold_1110", 1, 0, 4'b1110, 3, 8'h08, 1, 0, 0, 0);

    // Illegal code from LOCKED -> sticky ERROR, then clear with a bad code present.
    step("bad_0101", 1, 0, 4'b0101, 3, 8'h00, 0, 1, 0, 0);
    step("err_1111", 1, 0, 4'b1111, 4, 8'h10, 0, 1, 0, 0);
    step("err_0000", 1, 0, 4'b0000, 0, 8'h01, 0, 1, 0, 0);
    step("clr_1001", 1, 1, 4'b1001, 0, 8'h01, 0, 0, 0, 0);

    // Skip while LOCKING drops back to UNLOCKED without error.
    step("lk2_1000", 1, 0, 4'b1000, 1, 8'h02, 0, 0, 0, 0);
    step("lk2_1100", 1, 0, 4'b1100, 2, 8'h04, 0, 0, 0, 0);
    step("skip_1111", 1, 0, 4'b1111, 4, 8'h10, 0, 0, 0, 0);

    // Relock across the N-1 -> 0 boundary: not counted, FSM was LOCKING.
    step("rl_0111", 1, 0, 4'b0111, 5, 8'h20, 0, 0, 0, 0);
    step("rl_0011", 1, 0, 4'b0011, 6, 8'h40, 0, 0, 0, 0);
    step("rl_0001", 1, 0, 4'b0001, 7, 8'h80, 0, 0, 0, 0);
    step("rl_0000", 1, 0, 4'b0000, 0, 8'h01, 1, 0, 0, 0);
    step("rl_1000", 1, 0, 4'b1000, 1, 8'h02, 1, 0, 0, 0);
    for (int i = 2; i < 8; i++) begin
      step("rl_run", 1, 0, jc_code(i), i, oh(i), 1, 0, 0, 0);
    end
    step("rl_wrap", 1, 0, 4'b0000, 0, 8'h01, 1, 0, 1, 1);

    // Asynchronous reset mid-cycle, observed before any clock edge.
    @(negedge clk);
    #1;
    rst_n  = 1'b0;
    #1;
    t.cyc  = -1;
    t.name = "async_reset";
    t.exp  = pack(0, 8'h00, 0, 0, 0, 0);
    sb_q.push_back(t);
    ->chk_now;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst_idle", 0, 0, 4'b1100, 0, 8'h00, 0, 0, 0, 0);
    step("post_rst_1000", 1, 0, 4'b1000, 1, 8'h02, 0, 0, 0, 0);
    step("post_rst_1100", 1, 0, 4'b1100, 2, 8'h04, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
